// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for the two data-memory requesters plus the
// memory-side address/data/write-strobe bus owned by the arbiter.
interface dmem_arbiter_if;
    logic        p0_valid;
    logic        p0_ready;
    logic        p0_we;
    logic [3:0]  p0_be;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p0_err;

    logic        p1_valid;
    logic        p1_ready;
    logic        p1_we;
    logic [3:0]  p1_be;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;
    logic        p1_err;

    logic [31:0] dmem_addr;
    logic [31:0] dmem_DataW;
    logic        dmem_MemRW;
    logic [31:0] dmem_DataR;

    modport slave (
        input  p0_valid, p0_we, p0_be, p0_addr, p0_wdata,
        output p0_ready, p0_rvalid, p0_rdata, p0_err,
        input  p1_valid, p1_we, p1_be, p1_addr, p1_wdata,
        output p1_ready, p1_rvalid, p1_rdata, p1_err,
        output dmem_addr, dmem_DataW, dmem_MemRW,
        input  dmem_DataR
    );

    modport master (
        output p0_valid, p0_we, p0_be, p0_addr, p0_wdata,
        input  p0_ready, p0_rvalid, p0_rdata, p0_err,
        output p1_valid, p1_we, p1_be, p1_addr, p1_wdata,
        input  p1_ready, p1_rvalid, p1_rdata, p1_err,
        input  dmem_addr, dmem_DataW, dmem_MemRW,
        output dmem_DataR
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port word memory between two requesters;
// sub-word stores are performed as read-modify-write.
module dmem_arbiter #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic        WR_POL      = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus,
    output logic          busy
);
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              last_grant_r;
    logic              id_r;
    logic              we_r;
    logic              oor_r;
    logic [3:0]        be_r;
    logic [31:0]       wdata_r;
    logic [31:0]       addr_r;
    logic [31:0]       dataw_r;
    logic              memrw_r;
    logic [1:0]        rvalid_r;
    logic [1:0][31:0]  rdata_r;
    logic [1:0]        err_r;

    logic              grant_s;
    logic              hs_s;
    logic              sel_we_s;
    logic              sel_oor_s;
    logic              partial_s;
    logic [3:0]        sel_be_s;
    logic [31:0]       sel_addr_s;
    logic [31:0]       sel_wdata_s;

    function automatic logic [31:0] merge_bytes(input logic [3:0]  be,
                                                input logic [31:0] new_word,
                                                input logic [31:0] old_word);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return m;
    endfunction

    // Grant selection and request-field mux; ties go to the port not served last.
    always_comb begin
        grant_s     = 1'b0;
        sel_we_s    = bus.p0_we;
        sel_be_s    = bus.p0_be;
        sel_addr_s  = bus.p0_addr;
        sel_wdata_s = bus.p0_wdata;
        if (bus.p0_valid && bus.p1_valid) begin
            grant_s = ~last_grant_r;
        end else if (bus.p1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        if (grant_s) begin
            sel_we_s    = bus.p1_we;
            sel_be_s    = bus.p1_be;
            sel_addr_s  = bus.p1_addr;
            sel_wdata_s = bus.p1_wdata;
        end else begin
            sel_we_s    = bus.p0_we;
            sel_be_s    = bus.p0_be;
            sel_addr_s  = bus.p0_addr;
            sel_wdata_s = bus.p0_wdata;
        end
        hs_s      = (state_r == IDLE) && (grant_s ? bus.p1_valid : bus.p0_valid);
        sel_oor_s = (sel_addr_s >= ADDR_LIMIT);
        partial_s = we_r && !oor_r && (be_r != 4'b1111) && (be_r != 4'b0000);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = hs_s ? ACCESS : IDLE;
            ACCESS:  state_s = partial_s ? WRITE : RESP;
            WRITE:   state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latch, memory bus drive and response registers; the write strobe
    // is set one edge ahead so it is high exactly during the committing cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= 1'b1;
            id_r         <= 1'b0;
            we_r         <= 1'b0;
            oor_r        <= 1'b0;
            be_r         <= 4'b0000;
            wdata_r      <= 32'h0;
            addr_r       <= 32'h0;
            dataw_r      <= 32'h0;
            memrw_r      <= ~WR_POL;
            rvalid_r     <= 2'b00;
            rdata_r      <= 64'h0;
            err_r        <= 2'b00;
        end else begin
            rvalid_r <= 2'b00;
            memrw_r  <= ~WR_POL;
            case (state_r)
                IDLE: begin
                    if (hs_s) begin
                        id_r         <= grant_s;
                        last_grant_r <= grant_s;
                        we_r         <= sel_we_s;
                        be_r         <= sel_be_s;
                        wdata_r      <= sel_wdata_s;
                        oor_r        <= sel_oor_s;
                        addr_r       <= {sel_addr_s[31:2], 2'b00};
                        dataw_r      <= sel_wdata_s;
                        if (sel_we_s && (sel_be_s == 4'b1111) && !sel_oor_s) begin
                            memrw_r <= WR_POL;
                        end
                    end
                end
                ACCESS: begin
                    if (oor_r) begin
                        rdata_r[id_r] <= 32'h0;
                        err_r[id_r]   <= 1'b1;
                    end else if (!we_r) begin
                        rdata_r[id_r] <= bus.dmem_DataR;
                        err_r[id_r]   <= 1'b0;
                    end else begin
                        err_r[id_r]   <= 1'b0;
                    end
                    if (partial_s) begin
                        dataw_r <= merge_bytes(be_r, wdata_r, bus.dmem_DataR);
                        memrw_r <= WR_POL;
                    end else begin
                        rvalid_r[id_r] <= 1'b1;
                    end
                end
                WRITE: begin
                    rvalid_r[id_r] <= 1'b1;
                end
                RESP: begin
                    rvalid_r <= 2'b00;
                end
                default: begin
                    rvalid_r <= 2'b00;
                end
            endcase
        end
    end

    assign bus.p0_ready   = (state_r == IDLE) && !grant_s && bus.p0_valid;
    assign bus.p1_ready   = (state_r == IDLE) &&  grant_s && bus.p1_valid;
    assign bus.p0_rvalid  = rvalid_r[0];
    assign bus.p1_rvalid  = rvalid_r[1];
    assign bus.p0_rdata   = rdata_r[0];
    assign bus.p1_rdata   = rdata_r[1];
    assign bus.p0_err     = err_r[0];
    assign bus.p1_err     = err_r[1];
    assign bus.dmem_addr  = addr_r;
    assign bus.dmem_DataW = dataw_r;
    assign bus.dmem_MemRW = memrw_r;
    assign busy           = (state_r != IDLE);
endmodule
